// File: rtl/alu_writeback.sv
// Execute/writeback stage around an external combinational 8-bit ALU.
// One instruction in flight; operands read at acceptance, result and flags written back in WB.
//
// state | meaning
// IDLE  | ready for an instruction; operands latched on accept
// EXEC  | latched op/A/B driven to the ALU, result settling
// WB    | ALU result written to R[dst] (unless nowb), flags captured
module alu_writeback #(
  parameter int              DW       = 8,
  parameter int              AW       = 2,
  parameter logic [DW-1:0]   REG_INIT = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_dst,
  input  logic [AW-1:0] in_srca,
  input  logic [AW-1:0] in_srcb,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic          in_nowb,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_o,
  input  logic          alu_c,
  input  logic          alu_z,
  output logic          wb_valid,
  output logic [AW-1:0] wb_dst,
  output logic [DW-1:0] wb_data,
  output logic          flag_c,
  output logic          flag_z,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic          nowb_q, nowb_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic          flag_c_q, flag_c_d;
  logic          flag_z_q, flag_z_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_dst_q, wb_dst_d;
  logic [DW-1:0] wb_data_q, wb_data_d;

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign in_ready = rst_n && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    nowb_d     = nowb_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    regs_d     = regs_q;
    flag_c_d   = flag_c_q;
    flag_z_d   = flag_z_q;
    wb_valid_d = 1'b0;
    wb_dst_d   = wb_dst_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = in_op;
          dst_d   = in_dst;
          nowb_d  = in_nowb;
          opa_d   = regs_q[in_srca];
          opb_d   = in_use_imm ? in_imm : regs_q[in_srcb];
          state_d = EXEC;
        end
      end
      EXEC: state_d = WB;
      WB: begin
        flag_c_d   = alu_c;
        flag_z_d   = alu_z;
        wb_valid_d = 1'b1;
        wb_dst_d   = dst_q;
        wb_data_d  = alu_o;
        if (!nowb_q) regs_d[dst_q] = alu_o;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 4'b0000;
      dst_q      <= '0;
      nowb_q     <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= REG_INIT;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_dst_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      nowb_q     <= nowb_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      regs_q     <= regs_d;
      flag_c_q   <= flag_c_d;
      flag_z_q   <= flag_z_d;
      wb_valid_q <= wb_valid_d;
      wb_dst_q   <= wb_dst_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_op   = op_q;
  assign alu_a    = opa_q;
  assign alu_b    = opb_q;
  assign wb_valid = wb_valid_q;
  assign wb_dst   = wb_dst_q;
  assign wb_data  = wb_data_q;
  assign flag_c   = flag_c_q;
  assign flag_z   = flag_z_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with a behavioural ALU (ADD=0010, SUB=0011, others 0/c0/z1).
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_dst, in_srca, in_srcb;
  logic [7:0] in_imm;
  logic       in_use_imm, in_nowb;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_o;
  logic       alu_c, alu_z;
  logic       wb_valid;
  logic [1:0] wb_dst;
  logic [7:0] wb_data;
  logic       flag_c, flag_z;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DW(8), .AW(2), .REG_INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_srca(in_srca), .in_srcb(in_srcb),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_nowb(in_nowb),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  logic [8:0] alu_r;
  always_comb begin
    alu_r = 9'h000;
    case (alu_op)
      4'b0010: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0011: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_r = 9'h000;
    endcase
  end
  assign alu_o = alu_r[7:0];
  assign alu_c = alu_r[8];
  assign alu_z = (alu_r[7:0] == 8'h00);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {8'h00, dbg_data}, {8'h00, exp});
  endtask

  task automatic present(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [7:0] imm, input logic ui,
                         input logic nw);
    in_op = op; in_dst = dst; in_srca = sa; in_srcb = sb;
    in_imm = imm; in_use_imm = ui; in_nowb = nw; in_valid = 1'b1;
  endtask

  // Waits (bounded) until in_ready is high, then lets the accepting edge pass.
  task automatic accept(input string tag);
    int n = 0;
    while (!in_ready && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_accept_ready"}, {15'h0, in_ready}, 16'h0001);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 4'h0; in_dst = 2'd0; in_srca = 2'd0;
    in_srcb = 2'd0; in_imm = 8'h00; in_use_imm = 1'b0; in_nowb = 1'b0; dbg_addr = 2'd0;

    // 1. reset
    tick(); tick();
    chk("rst_ready", {15'h0, in_ready}, 16'h0000);
    chk("rst_wbv",   {15'h0, wb_valid}, 16'h0000);
    chk("rst_flags", {14'h0, flag_c, flag_z}, 16'h0000);
    chk("rst_alu",   {alu_op, 4'h0, alu_a}, 16'h0000);
    chk("rst_wb",    {6'h0, wb_dst, wb_data}, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {15'h0, in_ready}, 16'h0001);
    for (int i = 0; i < 4; i++) chk_reg("rst_reg", i[1:0], 8'h00);

    // 2. ADD imm: R1 = R0 + 5
    present(4'b0010, 2'd1, 2'd0, 2'd0, 8'h05, 1'b1, 1'b0);
    accept("add1");
    in_valid = 1'b0;
    chk("add1_exec_ready", {15'h0, in_ready}, 16'h0000);
    chk("add1_alu", {alu_op, 4'h0, alu_a}, {4'b0010, 4'h0, 8'h00});
    chk("add1_alub", {8'h00, alu_b}, 16'h0005);
    tick();
    chk("add1_wb_early", {15'h0, wb_valid}, 16'h0000);
    tick();
    chk("add1_wb", {7'h0, wb_valid, 6'h0, wb_dst}, 16'h0101);
    chk("add1_data", {8'h00, wb_data}, 16'h0005);
    chk("add1_flags", {14'h0, flag_c, flag_z}, 16'h0000);
    chk("add1_ready", {15'h0, in_ready}, 16'h0001);
    chk_reg("add1_r1", 2'd1, 8'h05);
    // R2 = R1 + FC -> 01 with carry
    present(4'b0010, 2'd2, 2'd1, 2'd0, 8'hFC, 1'b1, 1'b0);
    accept("add2");
    in_valid = 1'b0;
    chk("add1_wb_pulse_end", {15'h0, wb_valid}, 16'h0000);
    tick(); tick();
    chk("add2_wb", {7'h0, wb_valid, 6'h0, wb_dst}, 16'h0102);
    chk("add2_flags", {14'h0, flag_c, flag_z}, 16'h0002);
    chk_reg("add2_r2", 2'd2, 8'h01);

    // 3. compares (no register write)
    present(4'b0011, 2'd2, 2'd1, 2'd0, 8'h05, 1'b1, 1'b1);
    accept("cmp1");
    in_valid = 1'b0;
    chk("cmp1_flags_hold", {14'h0, flag_c, flag_z}, 16'h0002);
    tick(); tick();
    chk("cmp1_wb", {7'h0, wb_valid, wb_data}, 16'h0100);
    chk("cmp1_flags", {14'h0, flag_c, flag_z}, 16'h0001);
    chk_reg("cmp1_r2", 2'd2, 8'h01);
    present(4'b0011, 2'd2, 2'd1, 2'd0, 8'h06, 1'b1, 1'b1);
    accept("cmp2");
    in_valid = 1'b0;
    tick(); tick();
    chk("cmp2_wb", {7'h0, wb_valid, wb_data}, 16'h01FF);
    chk("cmp2_flags", {14'h0, flag_c, flag_z}, 16'h0002);
    chk_reg("cmp2_r2", 2'd2, 8'h01);

    // 4. back-to-back with in_valid held; fields change during EXEC
    present(4'b0010, 2'd3, 2'd1, 2'd0, 8'h10, 1'b1, 1'b0);
    chk("hs_ready0", {15'h0, in_ready}, 16'h0001);
    tick();
    present(4'b0010, 2'd0, 2'd2, 2'd0, 8'h03, 1'b1, 1'b0);
    chk("hs_ready1", {15'h0, in_ready}, 16'h0000);
    chk("hs_exec_ab", {alu_a, alu_b}, 16'h0510);
    chk("hs_flags_hold", {14'h0, flag_c, flag_z}, 16'h0002);
    tick();
    chk("hs_ready2", {15'h0, in_ready}, 16'h0000);
    chk("hs_wb_ab", {alu_a, alu_b}, 16'h0510);
    tick();
    chk("hs_ready3", {15'h0, in_ready}, 16'h0001);
    chk("hs_a_wb", {7'h0, wb_valid, wb_data}, 16'h0115);
    chk_reg("hs_r3", 2'd3, 8'h15);
    tick();
    in_valid = 1'b0;
    chk("hs_b_ab", {alu_a, alu_b}, 16'h0103);
    tick(); tick();
    chk("hs_b_wb", {7'h0, wb_valid, 6'h0, wb_dst}, 16'h0100);
    chk_reg("hs_r0", 2'd0, 8'h04);

    // 5. self-overwrite R1 = R1 + R1
    present(4'b0010, 2'd1, 2'd1, 2'd1, 8'hEE, 1'b0, 1'b0);
    accept("self");
    in_valid = 1'b0;
    tick(); tick();
    chk("self_wb", {7'h0, wb_valid, wb_data}, 16'h010A);
    chk_reg("self_r1", 2'd1, 8'h0A);

    // 6. reset during EXEC drops the instruction
    present(4'b0001, 2'd3, 2'd0, 2'd0, 8'hAA, 1'b1, 1'b0);
    accept("rstx");
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstx_ready", {15'h0, in_ready}, 16'h0000);
    chk_reg("rstx_r3_low", 2'd3, 8'h00);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rstx_no_wbv", {15'h0, wb_valid}, 16'h0000);
      tick();
    end
    chk("rstx_ready_idle", {15'h0, in_ready}, 16'h0001);
    chk_reg("rstx_r3", 2'd3, 8'h00);
    chk_reg("rstx_r1", 2'd1, 8'h00);
    chk("rstx_flags", {14'h0, flag_c, flag_z}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Execute/writeback stage wrapped around the 8-bit ALU. Accepts one instruction at a time over a valid/ready handshake and latches the source operands from a small register file. It then drives the ALU's op/A/B inputs and captures the ALU's result, carry and zero outputs. The result is written back to the register file and the flags are held for downstream branch logic.

Parameters:
DW, 8, datapath width; must equal the ALU width (8 is the only supported value)
AW, 2, register address width; the register file has 2**AW entries
REG_INIT, 8'h00, reset value of every register file entry

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  instruction offered
in_ready  out  1  stage can accept an instruction
in_op  in  4  ALU opcode, passed unchanged to the ALU
in_dst  in  AW  destination register
in_srca  in  AW  register feeding ALU A
in_srcb  in  AW  register feeding ALU B (unused when in_use_imm=1)
in_imm  in  DW  immediate operand
in_use_imm  in  1  1: B = in_imm; 0: B = R[in_srcb]
in_nowb  in  1  1: update flags only, no register write (compare)
alu_op  out  4  to ALU op
alu_a  out  DW  to ALU A
alu_b  out  DW  to ALU B
alu_o  in  DW  ALU result
alu_c  in  1  ALU carry (bit 8 of the 9-bit result)
alu_z  in  1  ALU zero
wb_valid  out  1  one-cycle pulse: writeback/flag update done this cycle
wb_dst  out  AW  register written (valid with wb_valid)
wb_data  out  DW  value written (valid with wb_valid)
flag_c  out  1  registered carry flag
flag_z  out  1  registered zero flag
dbg_addr  in  AW  debug read address
dbg_data  out  DW  combinational R[dbg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registers=REG_INIT.
  - flag_c=0, flag_z=0, wb_valid=0, wb_dst=0, wb_data=0.
  - alu_op=4'b0000, alu_a=0, alu_b=0.
  - in_ready=0 while rst_n=0, 1 on the first cycle after release.
- FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge t, latch op, dst, nowb, opA=R[srca], and opB=(use_imm?imm:R[srcb]) into internal registers; go to EXEC.
  - Operands are read at acceptance, so dst==srca/srcb is legal and uses the old values.
- EXEC: in_ready=0. alu_op/alu_a/alu_b are driven from the latched registers, not from the in_* ports. They are held stable for the whole EXEC and WB cycles, giving the combinational ALU a full cycle to settle. Go to WB.
- WB:
  - At the edge ending WB, capture alu_c into flag_c and alu_z into flag_z.
  - If nowb=0, write R[dst]=alu_o. If nowb=1, write no register.
  - wb_valid=1 for exactly one cycle following that edge, with wb_dst=dst and wb_data=alu_o. wb_valid pulses for compare instructions too.
  - Go to IDLE.
- Latency: instruction accepted at edge t; register and flags updated at edge t+2; wb_valid high during cycle t+2..t+3. Throughput is 1 instruction per 3 cycles.
- Back-to-back: in_ready returns high in the cycle after the WB edge. A dependent instruction accepted then reads the new value; no forwarding is needed.
- in_valid while in_ready=0 is ignored. The source must hold in_valid and the in_* fields until accepted; fields may change freely when not accepted.
- The ALU outputs are consumed verbatim. There is no reinterpretation of carry for subtract (borrow appears as alu_c=1 when A<B) or of NOT, and alu_z is not recomputed.
- Flags change only in WB; they hold across IDLE and EXEC.
- Reset mid-operation (EXEC or WB): the pending instruction is dropped with no writeback and no wb_valid, and all state is reset.
- dbg_data is a combinational read. A write in WB is visible on dbg_data in the cycle after the edge.
- Unused opcodes pass through; result and flags are whatever the ALU returns (0, c=0, z=1).

Test Plan:
1. Reset, then dbg_addr sweeps 0..3 -> all dbg_data=8'h00, flags 0, in_ready=1 after release.
2. ADD imm: op=0010, dst=1, srca=0 (R0=0), imm=8'h05 -> at t+2 R1=8'h05, wb_valid pulse with wb_data=8'h05, flag_c=0, flag_z=0. Then op=0010, dst=2, srca=1, imm=8'hFC -> R2=8'h01, flag_c=1, flag_z=0.
3. Compare: in_nowb=1, op=0011, srca=1 (8'h05), imm=8'h05 -> R unchanged, flag_z=1, flag_c=0, wb_valid still pulses. Repeat with imm=8'h06 -> flag_c=1, flag_z=0.
4. Handshake: hold in_valid=1 with two different instructions presented back to back -> in_ready pattern 1,0,0,1. The second instruction is accepted 3 cycles after the first. Changing in_* fields during EXEC does not alter alu_a/alu_b.
5. Self-overwrite: R1=8'h05, op=0010, dst=1, srca=1, srcb=1, use_imm=0 -> R1=8'h0A.
6. rst_n pulled low during EXEC of op=0001, imm=8'hAA, dst=3 -> R3 stays 8'h00, no wb_valid, FSM in IDLE after release.
